// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures register read data and decoded control for one instruction and
// presents them to EX one edge later. Inserts a one-cycle bubble (and asks
// IF/ID to hold) when the instruction in ID needs the result of a load that
// is still in EX, and counts those bubbles with a saturating counter.
//
// Flow control: ex_stall is a hold request from downstream. While it is high
// nothing in this stage changes: the EX registers and the bubble counter hold,
// and ifid_hold is raised so upstream keeps presenting the same instruction.
// An instruction therefore moves ID->EX exactly on an edge where ex_stall=0,
// flush=0 and load_use_stall=0. flush and the load-use bubble both replace
// the EX contents with an all-zero bubble.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [DW-1:0] id_src_data1,
  input  logic [DW-1:0] id_src_data2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          ex_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [3:0]    ex_opcode,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_data1,
  output logic [DW-1:0] ex_data2,
  output logic [DW-1:0] ex_imm,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          load_use_stall,
  output logic          ifid_hold,
  output logic [15:0]   bubble_cnt
);

  // Everything that travels from ID to EX, kept together so hold / bubble /
  // load are single assignments and cannot drift apart field by field.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [3:0]    opcode;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] imm;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } stage_t;

  // What the next edge does to the EX registers. This is the implicit
  // NORMAL / BUBBLE / HELD behaviour made explicit so it can be observed
  // and checked from one place.
  typedef enum logic [1:0] {
    ACT_LOAD     = 2'd0,  // normal advance from ID
    ACT_HOLD     = 2'd1,  // downstream stall, keep everything
    ACT_FLUSH    = 2'd2,  // branch redirect kills ID, bubble into EX
    ACT_LOAD_USE = 2'd3   // load-use hazard, bubble into EX and count it
  } action_t;

  stage_t  stage_q;
  stage_t  id_bundle;
  action_t action;
  logic    rs_hit;
  logic    rt_hit;
  logic [15:0] bubble_cnt_q;

  assign id_bundle = '{
    valid:     id_valid,
    pc:        id_pc,
    opcode:    id_opcode,
    rs:        id_rs,
    rt:        id_rt,
    rd:        id_rd,
    data1:     id_src_data1,
    data2:     id_src_data2,
    imm:       id_imm,
    reg_write: id_reg_write,
    mem_read:  id_mem_read,
    mem_write: id_mem_write
  };

  // Hazard detection: a load in EX whose destination is read by the valid,
  // unflushed instruction in ID. Register 0 is treated like any other, and
  // the load's reg_write bit is deliberately not consulted.
  always_comb begin
    rs_hit         = id_rs_used && (id_rs == stage_q.rd);
    rt_hit         = id_rt_used && (id_rt == stage_q.rd);
    load_use_stall = stage_q.valid && stage_q.mem_read && id_valid && !flush
                     && (rs_hit || rt_hit);
    ifid_hold      = load_use_stall || ex_stall;
  end

  // Priority select for the next edge: stall beats flush beats hazard.
  always_comb begin
    action = ACT_LOAD;
    if (ex_stall) begin
      action = ACT_HOLD;
    end else if (flush) begin
      action = ACT_FLUSH;
    end else if (load_use_stall) begin
      action = ACT_LOAD_USE;
    end
  end

  // EX register bank: hold, zero to a bubble, or capture ID as-is (an
  // invalid ID slot is captured unmasked; decode keeps its controls at 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      unique case (action)
        ACT_HOLD:     stage_q <= stage_q;
        ACT_FLUSH:    stage_q <= '0;
        ACT_LOAD_USE: stage_q <= '0;
        default:      stage_q <= id_bundle;
      endcase
    end
  end

  // Saturating count of load-use bubbles actually inserted; frozen by stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else if (action == ACT_LOAD_USE && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_pc        = stage_q.pc;
  assign ex_opcode    = stage_q.opcode;
  assign ex_rs        = stage_q.rs;
  assign ex_rt        = stage_q.rt;
  assign ex_rd        = stage_q.rd;
  assign ex_data1     = stage_q.data1;
  assign ex_data2     = stage_q.data2;
  assign ex_imm       = stage_q.imm;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_mem_write = stage_q.mem_write;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a hand-computed vector table, an asynchronous reset
// check, randomized traffic against a behavioural model, and counter
// saturation.
module tb_id_ex_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        id_valid, id_rs_used, id_rt_used;
  logic [15:0] id_pc, id_src_data1, id_src_data2, id_imm;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, flush, ex_stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [15:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic        load_use_stall, ifid_hold;
  logic [15:0] bubble_cnt;

  id_ex_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_src_data1(id_src_data1), .id_src_data2(id_src_data2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_stall(load_use_stall), .ifid_hold(ifid_hold), .bubble_cnt(bubble_cnt)
  );

  // ---------------- types ----------------
  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [3:0]  op, rs, rt, rd;
    logic        rsu, rtu;
    logic [15:0] d1, d2, imm;
    logic        rw, mr, mw, fl, st;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [3:0]  op, rs, rt, rd;
    logic [15:0] d1, d2, imm;
    logic        rw, mr, mw;
  } ex_t;

  localparam logic [1:0] K_LOAD = 2'd0, K_ZERO = 2'd1, K_HOLD = 2'd2;

  typedef struct {
    in_t         in;
    logic        lus;
    logic        hold;
    logic [1:0]  kind;
    logic [15:0] cnt;
  } vec_t;

  ex_t dut_ex;
  assign dut_ex = {ex_valid, ex_pc, ex_opcode, ex_rs, ex_rt, ex_rd,
                   ex_data1, ex_data2, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- helpers ----------------
  function automatic in_t mk(input logic v, input logic [15:0] pc, input logic [3:0] op,
                             input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                             input logic rsu, input logic rtu,
                             input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                             input logic rw, input logic mr, input logic mw,
                             input logic fl, input logic st);
    in_t r;
    r = '{valid: v, pc: pc, op: op, rs: rs, rt: rt, rd: rd, rsu: rsu, rtu: rtu,
          d1: d1, d2: d2, imm: imm, rw: rw, mr: mr, mw: mw, fl: fl, st: st};
    return r;
  endfunction

  function automatic ex_t ex_of(input in_t v);
    ex_t e;
    e = '{valid: v.valid, pc: v.pc, op: v.op, rs: v.rs, rt: v.rt, rd: v.rd,
          d1: v.d1, d2: v.d2, imm: v.imm, rw: v.rw, mr: v.mr, mw: v.mw};
    return e;
  endfunction

  function automatic vec_t mkvec(input in_t v, input logic lus, input logic hold,
                                 input logic [1:0] kind, input logic [15:0] cnt);
    vec_t r;
    r.in = v; r.lus = lus; r.hold = hold; r.kind = kind; r.cnt = cnt;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input in_t v);
    id_valid = v.valid; id_pc = v.pc; id_opcode = v.op;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_used = v.rsu; id_rt_used = v.rtu;
    id_src_data1 = v.d1; id_src_data2 = v.d2; id_imm = v.imm;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
    flush = v.fl; ex_stall = v.st;
  endtask

  // ---------------- reference model ----------------
  ex_t m_ex;
  int  m_cnt;

  function automatic logic model_hazard(input in_t v, input ex_t e);
    logic reads_load;
    reads_load = (v.rsu && v.rs == e.rd) || (v.rtu && v.rt == e.rd);
    return e.valid && e.mr && v.valid && !v.fl && reads_load;
  endfunction

  // One cycle: drive, check combinational outputs, advance model, check regs.
  task automatic step_model(input in_t v);
    logic lus;
    drive(v);
    #1;
    lus = model_hazard(v, m_ex);
    chk("load_use_stall", 128'(load_use_stall), 128'(lus));
    chk("ifid_hold", 128'(ifid_hold), 128'(lus | v.st));
    @(posedge clk);
    if (v.st) begin
      // nothing moves
    end else if (v.fl) begin
      m_ex = '0;
    end else if (lus) begin
      m_ex = '0;
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_ex = ex_of(v);
    end
    #1;
    chk("ex_regs", 128'(dut_ex), 128'(m_ex));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
  endtask

  function automatic in_t rand_in();
    in_t r;
    r.valid = ($urandom_range(0, 9) < 8);
    r.pc = 16'($urandom); r.op = 4'($urandom);
    r.rs = 4'($urandom_range(0, 3)); r.rt = 4'($urandom_range(0, 3));
    r.rd = 4'($urandom_range(0, 3));
    r.rsu = 1'($urandom); r.rtu = 1'($urandom);
    r.d1 = 16'($urandom); r.d2 = 16'($urandom); r.imm = 16'($urandom);
    r.mr = ($urandom_range(0, 2) == 0);
    r.mw = !r.mr && 1'($urandom);
    r.rw = 1'($urandom);
    if (!r.valid) begin
      r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
    end
    r.fl = ($urandom_range(0, 9) == 0);
    r.st = ($urandom_range(0, 4) == 0);
    return r;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[22];
  ex_t  exp_ex;
  in_t  lw5, use5;

  initial begin
    drive('0);
    // directed table, applied from the reset state
    vecs[0]  = mkvec(mk(1,16'h0010,1,1,2,3,0,0,16'h1234,16'hBEEF,0,1,0,0,0,0), 0,0,K_LOAD,0);
    vecs[1]  = mkvec(mk(1,16'h0012,4,1,0,5,1,0,16'h0100,0,16'h0004,1,1,0,0,0), 0,0,K_LOAD,0);
    vecs[2]  = mkvec(mk(1,16'h0014,1,5,2,6,1,1,16'hAAAA,16'h5555,0,1,0,0,0,0), 1,1,K_ZERO,1);
    vecs[3]  = mkvec(mk(1,16'h0014,1,5,2,6,1,1,16'hAAAA,16'h5555,0,1,0,0,0,0), 0,0,K_LOAD,1);
    vecs[4]  = mkvec(mk(1,16'h0016,4,2,0,5,1,0,16'h0200,0,16'h0008,1,1,0,0,0), 0,0,K_LOAD,1);
    vecs[5]  = mkvec(mk(1,16'h0018,2,7,5,8,1,0,16'h0001,16'h0002,0,1,0,0,0,0), 0,0,K_LOAD,1);
    vecs[6]  = mkvec(mk(1,16'h001A,4,3,0,5,1,0,16'h0300,0,16'h000C,1,1,0,0,0), 0,0,K_LOAD,1);
    vecs[7]  = mkvec(mk(1,16'h001C,1,5,5,6,1,1,16'h1111,16'h2222,0,1,0,0,1,0), 0,0,K_ZERO,1);
    vecs[8]  = mkvec(mk(1,16'h001E,4,3,0,5,1,0,16'h0400,0,16'h0010,1,1,0,0,0), 0,0,K_LOAD,1);
    vecs[9]  = mkvec(mk(1,16'h0020,1,5,0,6,1,0,16'h3333,0,0,1,0,0,0,1), 1,1,K_HOLD,1);
    vecs[10] = mkvec(mk(1,16'h0022,3,5,0,7,1,0,16'h4444,0,0,1,0,0,1,1), 0,1,K_HOLD,1);
    vecs[11] = mkvec(mk(1,16'h0024,3,1,2,7,1,1,16'h5555,0,0,1,0,0,0,1), 0,1,K_HOLD,1);
    vecs[12] = mkvec(mk(1,16'h0026,1,0,5,6,0,1,16'h6666,16'h0123,0,1,0,0,0,0), 1,1,K_ZERO,2);
    vecs[13] = mkvec(mk(1,16'h0026,1,0,5,6,0,1,16'h6666,16'h0123,0,1,0,0,0,0), 0,0,K_LOAD,2);
    vecs[14] = mkvec(mk(0,16'h0040,0,0,0,0,0,0,16'h00FF,0,0,0,0,0,0,0), 0,0,K_LOAD,2);
    vecs[15] = mkvec(mk(1,16'h0050,4,1,0,0,1,0,16'h0500,0,0,1,1,0,0,0), 0,0,K_LOAD,2);
    vecs[16] = mkvec(mk(1,16'h0052,1,0,3,4,1,0,16'h0600,0,0,1,0,0,0,0), 1,1,K_ZERO,3);
    vecs[17] = mkvec(mk(1,16'h0054,4,1,0,9,1,0,0,0,0,0,1,0,0,0), 0,0,K_LOAD,3);
    vecs[18] = mkvec(mk(1,16'h0056,1,2,9,4,0,1,16'h0700,0,0,1,0,0,0,0), 1,1,K_ZERO,4);
    vecs[19] = mkvec(mk(1,16'h0058,4,1,0,9,1,0,0,0,0,0,1,0,0,0), 0,0,K_LOAD,4);
    vecs[20] = mkvec(mk(0,16'h005A,0,9,0,0,1,0,0,0,0,0,0,0,0,0), 0,0,K_LOAD,4);
    vecs[21] = mkvec(mk(1,16'h0060,5,1,2,3,1,1,16'h7777,16'h8888,16'h0009,1,0,1,0,0), 0,0,K_LOAD,4);

    // reset state
    #12;
    chk("reset_ex", 128'(dut_ex), 128'(0));
    chk("reset_cnt", 128'(bubble_cnt), 128'(0));
    chk("reset_lus", 128'(load_use_stall), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    exp_ex = '0;
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("vec%0d_lus", i), 128'(load_use_stall), 128'(vecs[i].lus));
      chk($sformatf("vec%0d_hold", i), 128'(ifid_hold), 128'(vecs[i].hold));
      @(posedge clk); #1;
      if (vecs[i].kind == K_LOAD) exp_ex = ex_of(vecs[i].in);
      else if (vecs[i].kind == K_ZERO) exp_ex = '0;
      chk($sformatf("vec%0d_ex", i), 128'(dut_ex), 128'(exp_ex));
      chk($sformatf("vec%0d_cnt", i), 128'(bubble_cnt), 128'(vecs[i].cnt));
    end

    // asynchronous reset mid-cycle with EX populated, stall requested
    ex_stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_ex", 128'(dut_ex), 128'(0));
    chk("async_reset_cnt", 128'(bubble_cnt), 128'(0));
    chk("async_reset_lus", 128'(load_use_stall), 128'(0));
    chk("async_reset_hold", 128'(ifid_hold), 128'(1));
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    m_ex = '0;
    m_cnt = 0;

    // first edge after reset release behaves as a normal load
    step_model(mk(1,16'h0100,6,1,2,3,1,1,16'hCAFE,16'hF00D,16'h0001,1,0,0,0,0));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step_model(rand_in());
    end

    // saturation: preload the counter near its ceiling, then keep bubbling
    lw5  = mk(1,16'h0200,4,1,0,5,1,0,0,0,16'h0004,1,1,0,0,0);
    use5 = mk(1,16'h0202,1,5,0,6,1,0,16'h0042,0,0,1,0,0,0,0);
    force dut.bubble_cnt_q = 16'hFFFD;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = 65533;
    for (int i = 0; i < 5; i++) begin
      step_model(lw5);
      step_model(use5);
    end
    chk("saturated_cnt", 128'(bubble_cnt), 128'(16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
